// File: rtl/sad_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sad_ctrl_pkg
// Shared definitions for the customSad controller:
//   - state_t      : 3-bit binary state encoding of the sequencing FSM
//   - SAD_N        : number of elements in one SAD computation
//   - MEM_LAT_MIN/MAX : legal range of the A/B memory read latency
//   - WAIT_W       : width of the memory-latency wait counter
//   - iter_cnt_w() : width needed to count 0..max_iter without wrapping
// -----------------------------------------------------------------------------
package sad_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    WAIT  = 3'd3,
    ACCUM = 3'd4,
    STORE = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int SAD_N       = 256;
  localparam int MEM_LAT_MIN = 0;
  localparam int MEM_LAT_MAX = 3;
  localparam int WAIT_W      = 2;

  // The iteration counter must be able to hold max_iter itself, because
  // the watchdog compares against that exact value.
  function automatic int iter_cnt_w(input int max_iter);
    return (max_iter < 1) ? 1 : $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/sad_wait_timer.sv
// -----------------------------------------------------------------------------
// sad_wait_timer
// Loadable down-counter that spaces the memory read strobe from the
// accumulate strobe by the memory read latency.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  synchronous active-high reset (count -> 0)
//   load     in  load load_val (has priority over dec)
//   load_val in  value to load
//   dec      in  decrement by one, holds at zero
//   last     out count is at 1 or below: this is the final wait cycle
// -----------------------------------------------------------------------------
module sad_wait_timer
  import sad_ctrl_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Treating 0 as "last" too means a stray zero load can never strand the
  // FSM in WAIT.
  assign last = (count_reg <= W'(1));

endmodule

// File: rtl/sad_ctrl.sv
// -----------------------------------------------------------------------------
// sad_ctrl
// Sequencing FSM for the customSad datapath: one full SAD_N-element SAD
// computation per accepted go, with wait cycles inserted for the
// synchronous A/B memory read latency and an iteration watchdog.
// Parameters:
//   MEM_LAT  read latency from mem_rd_en to valid a/b data (0..3)
//   MAX_ITER watchdog limit on accumulate iterations per run
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   go           start request (only looked at in IDLE)
//   abort        cancel the current run
//   i_ld_256     datapath loop flag, high while i < 256
//   i_inc/i_clr  index strobes
//   sum_ld/sum_clr        accumulator strobes
//   sadreg_ld/sadreg_clr  result register strobes
//   mem_rd_en    A/B memory read strobe
//   busy         high in every state except IDLE
//   done         one-cycle pulse, result valid in sad
//   err          sticky watchdog error
// -----------------------------------------------------------------------------
module sad_ctrl
  import sad_ctrl_pkg::*;
#(
  parameter int MEM_LAT  = 1,
  parameter int MAX_ITER = SAD_N
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic abort,
  input  logic i_ld_256,
  output logic i_inc,
  output logic i_clr,
  output logic sum_ld,
  output logic sum_clr,
  output logic sadreg_ld,
  output logic sadreg_clr,
  output logic mem_rd_en,
  output logic busy,
  output logic done,
  output logic err
);

  // Out-of-range latencies are clamped so the 2-bit wait counter always
  // holds the programmed value.
  localparam int MEM_LAT_C = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                             (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN : MEM_LAT;
  localparam int ITER_W = iter_cnt_w(MAX_ITER);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_LAT_C);
  localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

  state_t            state_reg;
  state_t            state_next;
  logic [ITER_W-1:0] iter_reg;
  logic [ITER_W-1:0] iter_next;
  logic              err_reg;
  logic              err_next;

  logic              timer_load;
  logic              timer_dec;
  logic              timer_last;

  sad_wait_timer #(
    .W (WAIT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (WAIT_LOAD),
    .dec      (timer_dec),
    .last     (timer_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      iter_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      iter_reg  <= iter_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    iter_next  = iter_reg;
    err_next   = err_reg;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    i_inc      = 1'b0;
    i_clr      = 1'b0;
    sum_ld     = 1'b0;
    sum_clr    = 1'b0;
    sadreg_ld  = 1'b0;
    sadreg_clr = 1'b0;
    mem_rd_en  = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (go && !abort) begin
          state_next = INIT;
          err_next   = 1'b0;
        end
      end

      INIT: begin
        i_clr      = 1'b1;
        sum_clr    = 1'b1;
        sadreg_clr = 1'b1;
        iter_next  = '0;
        state_next = CHECK;
      end

      CHECK: begin
        if (!i_ld_256) begin
          state_next = STORE;
        end else if (iter_reg == ITER_MAX) begin
          // Datapath never dropped its loop flag: store whatever has been
          // accumulated and still finish with a done pulse.
          err_next   = 1'b1;
          state_next = STORE;
        end else begin
          mem_rd_en  = 1'b1;
          timer_load = 1'b1;
          state_next = (MEM_LAT_C == 0) ? ACCUM : WAIT;
        end
      end

      WAIT: begin
        timer_dec = 1'b1;
        if (timer_last) begin
          state_next = ACCUM;
        end
      end

      ACCUM: begin
        sum_ld = 1'b1;
        i_inc  = 1'b1;
        if (iter_reg != ITER_MAX) begin
          iter_next = iter_reg + 1'b1;
        end
        state_next = CHECK;
      end

      STORE: begin
        sadreg_ld  = 1'b1;
        state_next = DONE;
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort overrides every transition out of a running state; the strobes
    // decoded above for this cycle still go out.
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
    end
  end

  assign busy = (state_reg != IDLE);
  assign err  = err_reg;

endmodule

// File: tb/tb_sad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sad_ctrl
// Three controllers run side by side, each with a behavioural customSad
// datapath and A/B memories:
//   inst 0 : MEM_LAT=1, MAX_ITER=256
//   inst 1 : MEM_LAT=0, MAX_ITER=256
//   inst 2 : MEM_LAT=1, MAX_ITER=4, loop flag stuck high (watchdog)
// Expected results come from the rules: SAD by direct summation, done
// cycle from 4+N*(2+MEM_LAT).
// -----------------------------------------------------------------------------
module tb_sad_ctrl;
  import sad_ctrl_pkg::*;

  localparam int NI = 3;
  localparam int WD_ITER = 4;

  logic clk = 1'b0;
  logic rst;
  logic go_main;
  logic go_wd;
  logic abort;

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic [7:0] mem_a [SAD_N];
  logic [7:0] mem_b [SAD_N];

  int n_checks = 0;
  int n_fail   = 0;
  int go_cnt   = 0;

  int   busy_cnt_a  [NI];
  int   sumld_a     [NI];
  int   done_a      [NI];
  int   done_edge_a [NI];
  int   sad_a       [NI];
  logic busy_a      [NI];
  logic err_a       [NI];
  logic outs_any_a  [NI];

  function automatic int absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? int'(a - b) : int'(b - a);
  endfunction

  // ---------------------------------------------------------------------------
  // DUT instances with their datapath/memory environment
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int LAT  = (gi == 1) ? 0 : 1;
    localparam int MAXI = (gi == 2) ? WD_ITER : SAD_N;

    logic go_i, i_ld_256, i_inc, i_clr, sum_ld, sum_clr;
    logic sadreg_ld, sadreg_clr, mem_rd_en, busy, done, err;
    logic [8:0] i_reg;
    int         sum_reg;
    int         sad_reg;
    logic [7:0] a_q, b_q, a_cur, b_cur;
    int busy_cnt  = 0;
    int sumld_cnt = 0;
    int done_cnt  = 0;
    int done_edge = 0;

    assign go_i     = (gi == 2) ? go_wd : go_main;
    assign i_ld_256 = (gi == 2) ? 1'b1 : (i_reg < 9'd256);

    sad_ctrl #(
      .MEM_LAT  (LAT),
      .MAX_ITER (MAXI)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .go         (go_i),
      .abort      (abort),
      .i_ld_256   (i_ld_256),
      .i_inc      (i_inc),
      .i_clr      (i_clr),
      .sum_ld     (sum_ld),
      .sum_clr    (sum_clr),
      .sadreg_ld  (sadreg_ld),
      .sadreg_clr (sadreg_clr),
      .mem_rd_en  (mem_rd_en),
      .busy       (busy),
      .done       (done),
      .err        (err)
    );

    assign a_cur = (LAT == 0) ? mem_a[i_reg[7:0]] : a_q;
    assign b_cur = (LAT == 0) ? mem_b[i_reg[7:0]] : b_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        i_reg   <= '0;
        sum_reg <= 0;
        sad_reg <= 0;
        a_q     <= '0;
        b_q     <= '0;
      end else begin
        if (i_clr) i_reg <= '0;
        else if (i_inc) i_reg <= i_reg + 9'd1;
        if (mem_rd_en) begin
          a_q <= mem_a[i_reg[7:0]];
          b_q <= mem_b[i_reg[7:0]];
        end
        if (sum_clr) sum_reg <= 0;
        else if (sum_ld) sum_reg <= sum_reg + absdiff(a_cur, b_cur);
        if (sadreg_clr) sad_reg <= 0;
        else if (sadreg_ld) sad_reg <= sum_reg;
      end
    end

    always @(negedge clk) begin
      if (busy)   busy_cnt  <= busy_cnt + 1;
      if (sum_ld) sumld_cnt <= sumld_cnt + 1;
      if (done) begin
        done_cnt  <= done_cnt + 1;
        done_edge <= edge_cnt;
      end
    end

    assign busy_cnt_a[gi]  = busy_cnt;
    assign sumld_a[gi]     = sumld_cnt;
    assign done_a[gi]      = done_cnt;
    assign done_edge_a[gi] = done_edge;
    assign sad_a[gi]       = sad_reg;
    assign busy_a[gi]      = busy;
    assign err_a[gi]       = err;
    assign outs_any_a[gi]  = i_inc | i_clr | sum_ld | sum_clr | sadreg_ld |
                             sadreg_clr | mem_rd_en | busy | done | err;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int ref_sad();
    int s = 0;
    for (int k = 0; k < SAD_N; k++) begin
      int d = int'(mem_a[k]) - int'(mem_b[k]);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  function automatic int ref_done_cycle(input int lat);
    return 4 + SAD_N * (2 + lat);
  endfunction

  // ---------------------------------------------------------------------------
  // Checking and sequencing helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Current cycle number relative to the last accepted go (cycle 1 = INIT).
  function automatic int cur_cycle();
    return edge_cnt - go_cnt + 1;
  endfunction

  task automatic start_go(input bit with_wd);
    @(negedge clk);
    go_main = 1'b1;
    go_wd   = with_wd;
    @(posedge clk);
    #1;
    go_cnt  = edge_cnt;
    go_main = 1'b0;
    go_wd   = 1'b0;
  endtask

  task automatic to_cycle(input int c);
    while (cur_cycle() < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_go_main();
    go_main = 1'b1;
    @(posedge clk);
    #1;
    go_main = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    while ((busy_a[0] || busy_a[1] || busy_a[2]) && (k < limit)) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, "_idle_in_time"}, 32'(k < limit), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_check(input string tag, input bit extra_go);
    int s_busy  [NI];
    int s_sumld [NI];
    int s_done  [NI];
    int exp_sad;
    for (int g = 0; g < NI; g++) begin
      s_busy[g]  = busy_cnt_a[g];
      s_sumld[g] = sumld_a[g];
      s_done[g]  = done_a[g];
    end
    exp_sad = ref_sad();
    start_go(1'b1);
    chk({tag, "_wd_err_cleared"}, 32'(err_a[2]), 0);
    if (extra_go) begin
      to_cycle(10);
      pulse_go_main();
      to_cycle(400);
      pulse_go_main();
    end
    wait_idle(tag, 2000);
    for (int g = 0; g < 2; g++) begin
      int lat = (g == 1) ? 0 : 1;
      chk($sformatf("%s_done_cycle%0d", tag, g), 32'(done_edge_a[g] - go_cnt + 1), 32'(ref_done_cycle(lat)));
      chk($sformatf("%s_sad%0d", tag, g), 32'(sad_a[g]), 32'(exp_sad));
      chk($sformatf("%s_sum_ld%0d", tag, g), 32'(sumld_a[g] - s_sumld[g]), 32'(SAD_N));
      chk($sformatf("%s_busy_cycles%0d", tag, g), 32'(busy_cnt_a[g] - s_busy[g]), 32'(ref_done_cycle(lat)));
      chk($sformatf("%s_done_pulses%0d", tag, g), 32'(done_a[g] - s_done[g]), 1);
      chk($sformatf("%s_err%0d", tag, g), 32'(err_a[g]), 0);
    end
    chk({tag, "_wd_sum_ld"}, 32'(sumld_a[2] - s_sumld[2]), 32'(WD_ITER));
    chk({tag, "_wd_done"}, 32'(done_a[2] - s_done[2]), 1);
    chk({tag, "_wd_err"}, 32'(err_a[2]), 1);
    $display("run %s: sad0=%0d sad1=%0d expected=%0d", tag, sad_a[0], sad_a[1], exp_sad);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int s_done [NI];

    rst     = 1'b1;
    go_main = 1'b0;
    go_wd   = 1'b0;
    abort   = 1'b0;
    for (int k = 0; k < SAD_N; k++) begin
      mem_a[k] = 8'd50;
      mem_b[k] = 8'd100;
    end
    repeat (4) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) chk($sformatf("reset_outs%0d", g), 32'(outs_any_a[g]), 0);
    rst = 1'b0;
    $display("reset applied and released");

    // Nominal run with the fixed 50/100 pattern.
    run_check("nominal", 1'b0);

    // Random data, go re-asserted mid-run.
    for (int k = 0; k < SAD_N; k++) begin
      mem_a[k] = 8'($urandom_range(0, 255));
      mem_b[k] = 8'($urandom_range(0, 255));
    end
    run_check("go_ignored", 1'b1);

    // Abort at cycle 300.
    for (int g = 0; g < NI; g++) s_done[g] = done_a[g];
    start_go(1'b0);
    to_cycle(300);
    chk("abort_busy_before0", 32'(busy_a[0]), 1);
    chk("abort_busy_before1", 32'(busy_a[1]), 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy_after0", 32'(busy_a[0]), 0);
    chk("abort_busy_after1", 32'(busy_a[1]), 0);
    repeat (900) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("abort_no_done%0d", g), 32'(done_a[g] - s_done[g]), 0);
      chk($sformatf("abort_sad%0d", g), 32'(sad_a[g]), 0);
    end
    $display("abort at cycle 300 applied");

    run_check("after_abort", 1'b0);

    // Reset at cycle 200 of a run.
    start_go(1'b1);
    to_cycle(200);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) chk($sformatf("midrst_outs%0d", g), 32'(outs_any_a[g]), 0);
    rst = 1'b0;
    $display("reset at cycle 200 applied");

    // abort and go together in IDLE: abort wins.
    @(negedge clk);
    go_main = 1'b1;
    go_wd   = 1'b1;
    abort   = 1'b1;
    @(posedge clk);
    #1;
    go_main = 1'b0;
    go_wd   = 1'b0;
    abort   = 1'b0;
    for (int g = 0; g < NI; g++) chk($sformatf("abort_go_busy%0d", g), 32'(busy_a[g]), 0);
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) chk($sformatf("abort_go_busy_late%0d", g), 32'(busy_a[g]), 0);
    $display("abort with go in IDLE applied");

    for (int k = 0; k < SAD_N; k++) begin
      mem_a[k] = 8'($urandom_range(0, 255));
      mem_b[k] = 8'($urandom_range(0, 255));
    end
    run_check("final", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
